// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the data-memory load/store port.
// Turns each EX/MEM load/store into one word-addressed, byte-enabled req/ack
// transaction, stalls the pipeline while it is outstanding, and returns the
// aligned, extended load result.
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              EX_MEM_valid,
    input  logic [1:0]        EX_MEM_LS_bit,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_Ext_op,
    input  logic [31:0]       EX_MEM_addr,
    input  logic [31:0]       EX_MEM_wdata,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              bus_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LS_NONE = 2'b00,
        LS_WORD = 2'b01,
        LS_HALF = 2'b10,
        LS_BYTE = 2'b11
    } ls_t;

    // Last REQ cycle index (counter starts at 0 on entry to REQ).
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    ls_t         size_in;
    ls_t         size_q;
    logic [1:0]  off_q;
    logic        ext_q;
    logic [7:0]  wait_cnt;

    logic        go;
    logic        misaligned;
    logic        timed_out;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] rdata_ext;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    assign size_in    = ls_t'(EX_MEM_LS_bit);
    assign go         = EX_MEM_valid && (size_in != LS_NONE) && (state == IDLE);
    assign timed_out  = (wait_cnt == TIMEOUT_LAST);

    // Decode alignment, byte-lane enables and lane-replicated store data.
    // NOTE: always_comb uses blocking '=' and assigns every output a default
    // first, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b0000;
        wdata_next = 32'd0;
        unique case (size_in)
            LS_WORD: begin
                misaligned = (EX_MEM_addr[1:0] != 2'b00);
                be_next    = 4'b1111;
                wdata_next = EX_MEM_wdata;
            end
            LS_HALF: begin
                misaligned = EX_MEM_addr[0];
                be_next    = EX_MEM_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{EX_MEM_wdata[15:0]}};
            end
            LS_BYTE: begin
                be_next    = 4'b0001 << EX_MEM_addr[1:0];
                wdata_next = {4{EX_MEM_wdata[7:0]}};
            end
            default: ;
        endcase
        if (!EX_MEM_MemWrite) begin
            wdata_next = 32'd0;
        end
    end

    // Extract the addressed lane of the read word and extend it.
    always_comb begin
        half_lane = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        byte_lane = dm_rdata[{off_q, 3'b000} +: 8];
        rdata_ext = dm_rdata;
        unique case (size_q)
            LS_HALF: rdata_ext = {{16{ext_q & half_lane[15]}}, half_lane};
            LS_BYTE: rdata_ext = {{24{ext_q & byte_lane[7]}}, byte_lane};
            default: rdata_ext = dm_rdata;
        endcase
    end

    // Next-state logic and the combinational stall.
    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        unique case (state)
            IDLE: begin
                if (go && !misaligned) begin
                    next_state = REQ;
                    mem_stall  = 1'b1;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dm_ack || timed_out) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Stall must read 0 while reset is held, even if EX/MEM still
        // presents a valid access.
        if (!reset) begin
            mem_stall = 1'b0;
        end
    end

    // State register.
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transaction registers, wait counter and one-cycle status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_be      <= 4'b0000;
            dm_addr    <= '0;
            dm_wdata   <= 32'd0;
            size_q     <= LS_NONE;
            off_q      <= 2'b00;
            ext_q      <= 1'b0;
            wait_cnt   <= 8'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go && misaligned) begin
                        misalign <= 1'b1;
                    end else if (go) begin
                        dm_req   <= 1'b1;
                        dm_we    <= EX_MEM_MemWrite;
                        dm_be    <= be_next;
                        dm_addr  <= EX_MEM_addr[ADDR_W+1:2];
                        dm_wdata <= wdata_next;
                        size_q   <= size_in;
                        off_q    <= EX_MEM_addr[1:0];
                        ext_q    <= EX_MEM_Ext_op;
                        wait_cnt <= 8'd0;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        dm_req   <= 1'b0;
                        wait_cnt <= 8'd0;
                        if (!dm_we) begin
                            load_data  <= rdata_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        dm_req    <= 1'b0;
                        wait_cnt  <= 8'd0;
                        bus_err   <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with hand-computed expectations for
// mem_access_unit (word/half/byte loads and stores, misalign, timeout, reset).
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        EX_MEM_valid;
    logic [1:0]  EX_MEM_LS_bit;
    logic        EX_MEM_MemWrite;
    logic        EX_MEM_Ext_op;
    logic [31:0] EX_MEM_addr;
    logic [31:0] EX_MEM_wdata;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(.ADDR_W(10), .TIMEOUT(15)) dut (
        .clock           (clock),
        .reset           (reset),
        .EX_MEM_valid    (EX_MEM_valid),
        .EX_MEM_LS_bit   (EX_MEM_LS_bit),
        .EX_MEM_MemWrite (EX_MEM_MemWrite),
        .EX_MEM_Ext_op   (EX_MEM_Ext_op),
        .EX_MEM_addr     (EX_MEM_addr),
        .EX_MEM_wdata    (EX_MEM_wdata),
        .mem_stall       (mem_stall),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .misalign        (misalign),
        .bus_err         (bus_err),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_be           (dm_be),
        .dm_addr         (dm_addr),
        .dm_wdata        (dm_wdata),
        .dm_ack          (dm_ack),
        .dm_rdata        (dm_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results observed over one access.
    logic [3:0]  o_be;
    logic        o_we;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;
    int          o_stall, o_req, o_lv, o_mis, o_berr, o_unstable;
    logic [31:0] o_ld;

    // Present one access, act as the pipeline (advance when mem_stall is low
    // at the sampling point) and as memory (ack in REQ cycle ack_after; 0 never).
    task automatic do_access(input logic [1:0] ls, input logic we, input logic ext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_after);
        bit done = 0;
        o_be = '0; o_we = 0; o_addr = '0; o_wdata = '0;
        o_stall = 0; o_req = 0; o_lv = 0; o_mis = 0; o_berr = 0; o_unstable = 0;
        @(posedge clock); #1;
        EX_MEM_valid = 1; EX_MEM_LS_bit = ls; EX_MEM_MemWrite = we;
        EX_MEM_Ext_op = ext; EX_MEM_addr = addr; EX_MEM_wdata = wdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            if (mem_stall) o_stall++;
            if (load_valid) o_lv++;
            if (misalign) o_mis++;
            if (bus_err) o_berr++;
            if (dm_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_be = dm_be; o_we = dm_we; o_addr = dm_addr; o_wdata = dm_wdata;
                    // Scramble the EX/MEM inputs; registered copies must hold.
                    EX_MEM_addr = 32'hFFFF_FFFF; EX_MEM_wdata = 32'h5A5A_5A5A;
                    EX_MEM_LS_bit = 2'b01; EX_MEM_MemWrite = ~we;
                end else if (dm_be !== o_be || dm_we !== o_we ||
                             dm_addr !== o_addr || dm_wdata !== o_wdata) begin
                    o_unstable++;
                end
                if (o_req == ack_after) begin
                    dm_ack = 1; dm_rdata = rdata;
                end
            end
            if (!mem_stall) done = 1;
            @(posedge clock); #1;
            dm_ack = 0; dm_rdata = 32'h1111_1111;
        end
        if (!done) check("access_bound", 0, 1);
        EX_MEM_valid = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (mem_stall) o_stall++;
            if (load_valid) o_lv++;
            if (misalign) o_mis++;
            if (bus_err) o_berr++;
            if (dm_req) o_req++;
        end
        o_ld = load_data;
    endtask

    initial begin
        reset = 0; EX_MEM_valid = 0; EX_MEM_LS_bit = 2'b00; EX_MEM_MemWrite = 0;
        EX_MEM_Ext_op = 0; EX_MEM_addr = 0; EX_MEM_wdata = 0;
        dm_ack = 0; dm_rdata = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", 32'(dm_req), 0);
        check("rst_stall", 32'(mem_stall), 0);
        check("rst_outs", {dm_we, dm_be, load_valid, misalign, bus_err}, 0);
        check("rst_addr", 32'(dm_addr), 0);
        check("rst_ld", load_data, 0);
        @(negedge clock); reset = 1;

        // Word store 0x10.
        do_access(2'b01, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1);
        check("ws_addr", 32'(o_addr), 4);
        check("ws_be", 32'(o_be), 32'hF);
        check("ws_we", 32'(o_we), 1);
        check("ws_wdata", o_wdata, 32'hDEAD_BEEF);
        check("ws_stall", o_stall, 2);
        check("ws_lv", o_lv, 0);
        check("ws_stable", o_unstable, 0);

        // Byte load 0x13, sign-extended, ack in 3rd REQ cycle.
        do_access(2'b11, 0, 1, 32'h0000_0013, 0, 32'h80AA_5501, 3);
        check("bl_be", 32'(o_be), 32'h8);
        check("bl_wdata", o_wdata, 0);
        check("bl_we", 32'(o_we), 0);
        check("bl_ld_s", o_ld, 32'hFFFF_FF80);
        check("bl_lv", o_lv, 1);
        check("bl_stall", o_stall, 4);
        check("bl_stable", o_unstable, 0);

        // Same, zero-extended.
        do_access(2'b11, 0, 0, 32'h0000_0013, 0, 32'h80AA_5501, 3);
        check("bl_ld_z", o_ld, 32'h0000_0080);
        check("bl_lv_z", o_lv, 1);

        // Half store 0x22; load_data must hold the last load result.
        do_access(2'b10, 1, 0, 32'h0000_0022, 32'h1234_ABCD, 0, 1);
        check("hs_be", 32'(o_be), 32'hC);
        check("hs_wdata", o_wdata, 32'hABCD_ABCD);
        check("hs_addr", 32'(o_addr), 8);
        check("hs_ld_hold", o_ld, 32'h0000_0080);
        check("hs_lv", o_lv, 0);

        // Half load 0x22, sign-extended; ack on 2nd REQ cycle.
        do_access(2'b10, 0, 1, 32'h0000_0022, 0, 32'hABCD_0000, 2);
        check("hl_be", 32'(o_be), 32'hC);
        check("hl_ld", o_ld, 32'hFFFF_ABCD);
        check("hl_stall", o_stall, 3);

        // Byte store lane 1.
        do_access(2'b11, 1, 0, 32'h0000_0005, 32'h0000_00E7, 0, 1);
        check("bs_be", 32'(o_be), 32'h2);
        check("bs_wdata", o_wdata, 32'hE7E7_E7E7);

        // Misaligned word load 0x06.
        do_access(2'b01, 0, 0, 32'h0000_0006, 0, 0, 1);
        check("mis_req", o_req, 0);
        check("mis_pulse", o_mis, 1);
        check("mis_stall", o_stall, 0);

        // Timeout: ack never arrives.
        do_access(2'b01, 0, 0, 32'h0000_0020, 0, 0, 0);
        check("to_req_cycles", o_req, 15);
        check("to_berr", o_berr, 1);
        check("to_ld", o_ld, 0);
        check("to_lv", o_lv, 0);
        check("to_stall", o_stall, 16);
        check("to_req_low", 32'(dm_req), 0);

        // Reset in the middle of REQ.
        @(posedge clock); #1;
        EX_MEM_valid = 1; EX_MEM_LS_bit = 2'b01; EX_MEM_MemWrite = 0; EX_MEM_addr = 32'h80;
        repeat (3) @(posedge clock);
        #3;
        check("pre_rst_req", 32'(dm_req), 1);
        reset = 0; #1;
        check("midrst_req", 32'(dm_req), 0);
        check("midrst_stall", 32'(mem_stall), 0);
        @(posedge clock); #1; EX_MEM_valid = 0;
        @(negedge clock); reset = 1;

        // Word load 0x40 after reset.
        do_access(2'b01, 0, 0, 32'h0000_0040, 0, 32'h0000_0007, 1);
        check("post_addr", 32'(o_addr), 32'h10);
        check("post_ld", o_ld, 7);
        check("post_lv", o_lv, 1);
        check("post_stall", o_stall, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory load/store interface, in the MEM stage between the EX/MEM pipeline register and a synchronous data memory. Converts each EX/MEM load/store into a single word-addressed, byte-enabled memory transaction with a req/ack handshake. Stalls the pipeline while the transaction is outstanding. Returns the aligned, sign- or zero-extended load result.

Parameters:
ADDR_W, 10, width of the word address driven to memory (covers byte address bits [ADDR_W+1:2])
TIMEOUT, 15, maximum REQ cycles waiting for dm_ack before a bus error is flagged (1..255)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
EX_MEM_valid  input  1  EX/MEM holds a valid instruction
EX_MEM_LS_bit  input  2  access size: 00 NONE, 01 WORD, 10 HALF, 11 BYTE
EX_MEM_MemWrite  input  1  1 = store, 0 = load
EX_MEM_Ext_op  input  1  1 = sign-extend load, 0 = zero-extend
EX_MEM_addr  input  32  byte address
EX_MEM_wdata  input  32  store data (low bits significant for HALF/BYTE)
mem_stall  output  1  freeze IF..EX/MEM this cycle
load_data  output  32  extended load result, valid when load_valid
load_valid  output  1  one-cycle pulse, load completed
misalign  output  1  one-cycle pulse, misaligned access dropped
bus_err  output  1  one-cycle pulse, access timed out
dm_req  output  1  memory request
dm_we  output  1  write enable
dm_be  output  4  byte-lane enables, bit i = bits [8i+7:8i]
dm_addr  output  ADDR_W  word address
dm_wdata  output  32  lane-replicated write data
dm_ack  input  1  memory accepted request (store done, or dm_rdata valid)
dm_rdata  input  32  read word

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0 immediately: dm_req, dm_we, dm_be, dm_addr, dm_wdata, load_data, load_valid, misalign, bus_err, mem_stall. Timeout counter cleared. A transaction in flight is abandoned; dm_req drops without waiting for ack.
- go = EX_MEM_valid & (EX_MEM_LS_bit != NONE) & state==IDLE.
- Misaligned: WORD with addr[1:0]!=0, or HALF with addr[0]!=0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - go & aligned: mem_stall=1 (combinational). Next edge: REQ, registering dm_addr=addr[ADDR_W+1:2], dm_we=MemWrite, dm_be, dm_wdata, ext_op, lane offset addr[1:0]. dm_req=1.
  - go & misaligned: no memory access, mem_stall=0, misalign=1 next cycle. Stay IDLE.
- Byte enables:
  - WORD: 1111.
  - HALF: addr[1]=0 gives 0011; addr[1]=1 gives 1100.
  - BYTE: 0001 << addr[1:0].
- Write data:
  - WORD: wdata.
  - HALF: {wdata[15:0], wdata[15:0]}.
  - BYTE: {4{wdata[7:0]}}.
  - Loads drive dm_wdata=0, with dm_be still marking the lanes.
- REQ:
  - dm_req=1 and all dm_* held stable. mem_stall=1. Counter increments each cycle.
  - dm_ack sampled at edge: to RESP, dm_req=0, counter cleared. For loads, capture the extracted lane:
    - WORD: rdata.
    - HALF: rdata[16*a1+15:16*a1].
    - BYTE: rdata[8*a+7:8*a].
    - Extend to 32 bits per ext_op. Assign load_data.
  - Counter reaches TIMEOUT without ack: to RESP with bus_err=1, load_data=0, dm_req=0.
  - dm_ack while not in REQ is ignored.
- RESP:
  - mem_stall=0. load_valid=1 for loads that completed without error. bus_err held for this single cycle.
  - Next edge: IDLE. The pipeline advances on that edge, so a back-to-back access is seen in IDLE the following cycle.
- Latency: dm_ack in the first REQ cycle gives 2 stall cycles (IDLE detect + REQ), with the result in the 3rd cycle. Each extra ack-wait cycle adds 1.
- load_data holds its last value until the next load completes or bus_err occurs.
- Stores never pulse load_valid.
- EX_MEM_* changes while in REQ/RESP are ignored because the registered copies are used.

Test Plan:
- Word store addr=0x0000_0010, wdata=0xDEADBEEF, dm_ack in 1st REQ cycle -> dm_addr=4, dm_be=1111, dm_we=1, dm_wdata=0xDEADBEEF; mem_stall high exactly 2 cycles; no load_valid.
- Byte load addr=0x13, Ext_op=1, dm_rdata=0x80AA_5501, ack after 3 REQ cycles -> dm_be=1000; load_data=0xFFFF_FF80, load_valid 1 cycle; mem_stall high 4 cycles. Repeat with Ext_op=0 -> 0x0000_0080.
- Half store addr=0x22, wdata=0x1234_ABCD -> dm_be=1100, dm_wdata=0xABCD_ABCD. Half load same address, Ext_op=1, rdata=0xABCD_0000 -> load_data=0xFFFF_ABCD.
- Word load addr=0x06 -> no dm_req, misalign pulses 1 cycle, mem_stall never asserted.
- Load with dm_ack held 0 -> bus_err pulses after 15 REQ cycles, load_data=0, dm_req falls, FSM returns to IDLE.
- Reset asserted mid-REQ -> dm_req and mem_stall drop immediately. After release, a new word load at 0x40 with rdata=0x0000_0007 completes normally with load_data=7.
